// File: rtl/oh_lutfifo_pkg.sv
// ---------------------------------------------------------------------------
// oh_lutfifo_pkg
// Shared constants and types for the LUT-RAM FIFO controller.
//   LF_DEPTH      : number of RAM words (32x1 dual-port LUT RAM columns)
//   LF_AW         : RAM address width
//   LF_CW         : occupancy count width (0..33 fits in 6 bits)
//   LF_AFULL_DEF  : default almost-full threshold  (OH_LUTFIFO_FLAGS_EN builds)
//   LF_AEMPTY_DEF : default almost-empty threshold (OH_LUTFIFO_FLAGS_EN builds)
// ---------------------------------------------------------------------------
package oh_lutfifo_pkg;

    localparam int LF_DEPTH      = 32;
    localparam int LF_AW         = 5;
    localparam int LF_CW         = 6;
    localparam int LF_AFULL_DEF  = 28;
    localparam int LF_AEMPTY_DEF = 2;

    // Output register occupancy: either empty or holding one word.
    typedef enum logic {
        OS_EMPTY = 1'b0,
        OS_HOLD  = 1'b1
    } ostage_state_e;

    // Total occupancy = words in RAM + word in the output register.
    function automatic logic [LF_CW-1:0] lf_total(input logic [LF_CW-1:0] mem_count,
                                                  input logic             out_valid);
        return mem_count + {{(LF_CW-1){1'b0}}, out_valid};
    endfunction

endpackage

// File: rtl/oh_lutfifo_ostage.sv
// ---------------------------------------------------------------------------
// oh_lutfifo_ostage
// Output register of the LUT-RAM FIFO. Loads the word presented on the
// combinational RAM read port whenever the RAM has data and the register is
// empty or being drained; drops out_valid on a pop that has nothing to reload.
//   clk, nreset      : clock, asynchronous active-low reset
//   mem_nonempty_i   : RAM holds at least one word
//   out_ready_i      : consumer takes the current word
//   rdata_i [DW]     : combinational RAM read data at rd_ptr
//   load_o           : register loads this cycle (advance rd_ptr)
//   valid_d_o        : next-state out_valid (for next-state count/flags)
//   out_valid_o      : register holds a word
//   out_data_o [DW]  : register contents
// ---------------------------------------------------------------------------
module oh_lutfifo_ostage
    import oh_lutfifo_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          mem_nonempty_i,
    input  logic          out_ready_i,
    input  logic [DW-1:0] rdata_i,
    output logic          load_o,
    output logic          valid_d_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o
);

    ostage_state_e state_q, state_d;
    logic [DW-1:0] data_q,  data_d;
    logic          load;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        load    = mem_nonempty_i & ((state_q == OS_EMPTY) | out_ready_i);
        if (load) begin
            state_d = OS_HOLD;
            data_d  = rdata_i;
        end else if ((state_q == OS_HOLD) && out_ready_i) begin
            // Pop with nothing behind it; data is left as-is.
            state_d = OS_EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= OS_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign load_o      = load;
    assign valid_d_o   = (state_d == OS_HOLD);
    assign out_valid_o = (state_q == OS_HOLD);
    assign out_data_o  = data_q;

endmodule

// File: rtl/oh_lutram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// oh_lutram_fifo_ctrl
// First-word-fall-through FIFO controller around a 32-deep dual-port LUT RAM
// (one 32x1 column per data bit, instantiated by the parent). Drives the RAM
// write port and read address, and registers read data into an output stage.
//   clk, nreset               : clock (also RAM write clock), async active-low reset
//   in_valid/in_data/in_ready : producer handshake
//   out_valid/out_data/out_ready : consumer handshake
//   count [6]                 : occupancy 0..33 (RAM + output register)
//   ram_we/ram_waddr/ram_wdata: RAM write port
//   ram_raddr/ram_rdata       : RAM read address and combinational read data
//   almost_full/almost_empty  : registered thresholds on count
// Build option: OH_LUTFIFO_FLAGS_EN enables the AFULL/AEMPTY parameters and the
// almost_full/almost_empty flags; otherwise both flags are tied low.
// ---------------------------------------------------------------------------
module oh_lutram_fifo_ctrl
    import oh_lutfifo_pkg::*;
#(
    parameter int DW = 32
`ifdef OH_LUTFIFO_FLAGS_EN
    ,
    parameter int AFULL  = LF_AFULL_DEF,
    parameter int AEMPTY = LF_AEMPTY_DEF
`endif
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    input  logic             out_ready,
    output logic [LF_CW-1:0] count,
    output logic             ram_we,
    output logic [LF_AW-1:0] ram_waddr,
    output logic [DW-1:0]    ram_wdata,
    output logic [LF_AW-1:0] ram_raddr,
    input  logic [DW-1:0]    ram_rdata,
    output logic             almost_full,
    output logic             almost_empty
);

    logic [LF_AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [LF_AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [LF_CW-1:0] mem_count_q, mem_count_d;
    logic             push;
    logic             load;
    logic             out_valid_d;

    // Gated by nreset so nothing is accepted while reset is asserted.
    assign in_ready  = nreset & (mem_count_q != LF_CW'(LF_DEPTH));
    assign push      = in_valid & in_ready;

    // Written words always go through the RAM; there is no bypass to the
    // output register, which gives the two-edge fall-through latency.
    assign ram_we    = push;
    assign ram_waddr = wr_ptr_q;
    assign ram_wdata = in_data;
    assign ram_raddr = rd_ptr_q;

    oh_lutfifo_ostage #(
        .DW (DW)
    ) u_ostage (
        .clk            (clk),
        .nreset         (nreset),
        .mem_nonempty_i (mem_count_q != '0),
        .out_ready_i    (out_ready),
        .rdata_i        (ram_rdata),
        .load_o         (load),
        .valid_d_o      (out_valid_d),
        .out_valid_o    (out_valid),
        .out_data_o     (out_data)
    );

    // 5-bit pointers wrap 31 -> 0 on their own; mem_count tells full from empty.
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + LF_AW'(1) : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + LF_AW'(1) : rd_ptr_q;
        mem_count_d = mem_count_q;
        case ({push, load})
            2'b10:   mem_count_d = mem_count_q + LF_CW'(1);
            2'b01:   mem_count_d = mem_count_q - LF_CW'(1);
            default: mem_count_d = mem_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
        end
    end

    assign count = lf_total(mem_count_q, out_valid);

`ifdef OH_LUTFIFO_FLAGS_EN
    logic [LF_CW-1:0] count_d;
    logic             afull_q;
    logic             aempty_q;

    // Flags are registered from next-state count so they line up with count.
    assign count_d = lf_total(mem_count_d, out_valid_d);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (count_d >= LF_CW'(AFULL));
            aempty_q <= (count_d <= LF_CW'(AEMPTY));
        end
    end

    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
`else
    logic unused_valid_d;
    assign unused_valid_d = out_valid_d;
    assign almost_full    = 1'b0;
    assign almost_empty   = 1'b0;
`endif

endmodule

// File: doc/oh_lutram_fifo_ctrl.md
# oh_lutram_fifo_ctrl

Sequencing controller for a 32-deep dual-port LUT RAM (one 32x1 dual-port column per data bit). It turns the RAM into a first-word-fall-through FIFO with valid/ready handshakes on both sides. It drives the write port (address, write enable, data) and the read address, and registers the read data into an output stage. It sits between producer and consumer logic, with the RAM columns instantiated alongside it at the parent level.

## Interface
- DW, 32, data width; equals the number of RAM columns
- clk  in  1  single clock; also drives the RAM write clock
- nreset  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a word
- in_data  in  DW  producer word
- in_ready  out  1  controller can accept a word
- out_valid  out  1  output register holds a word
- out_data  out  DW  output register contents
- out_ready  in  1  consumer takes the word
- count  out  6  total occupancy, 0..33 (RAM plus output register)
- ram_we  out  1  RAM write enable
- ram_waddr  out  5  RAM write/single-port address (A4..A0)
- ram_wdata  out  DW  RAM write data (D per column)
- ram_raddr  out  5  RAM read address (DPRA4..DPRA0)
- ram_rdata  in  DW  combinational RAM read data (DPO per column)
- almost_full  out  1  see Configuration
- almost_empty  out  1  see Configuration

## Operation
- State: wr_ptr[4:0], rd_ptr[4:0], mem_count[5:0] (0..32), out_valid, out_data.
- in_ready = nreset & (mem_count != 32). It is combinational from registered state and does not depend on out_ready.
- push = in_valid & in_ready; ram_we = push; ram_waddr = wr_ptr; ram_wdata = in_data.
- load = (mem_count != 0) & (!out_valid | out_ready); ram_raddr = rd_ptr.
- On push: wr_ptr++ at the edge.
- On load: out_data <= ram_rdata, rd_ptr++, out_valid <= 1.
- On pop without load (out_valid & out_ready & mem_count == 0): out_valid <= 0. out_data holds its value.
- mem_count update: +1 on push only; -1 on load only; unchanged on both or neither.
- count = mem_count + out_valid.
- Pointers are 5-bit and wrap 31 -> 0 naturally. There is no extra wrap bit; mem_count distinguishes full from empty.
- Write data never bypasses the RAM. A word pushed into an empty FIFO passes through the RAM before reaching the output register.

## Timing
- Reset (async assert, sync release by the parent) sets these values: wr_ptr=0, rd_ptr=0, mem_count=0, out_valid=0, out_data=0, count=0, in_ready=0, ram_we=0, almost_full=0, almost_empty=0 (flags macro-dependent, see Configuration).
- After release: in_ready=1 in the first cycle.
- Latency: push accepted at edge k into an empty FIFO gives out_valid=1 with that word after edge k+1.
- Throughput: one push and one pop per cycle sustained, with no bubbles once out_valid=1.
- Full:
  - mem_count=32 gives in_ready=0.
  - A pop with load at edge k raises in_ready after edge k. There is no same-cycle pass-through.
- Empty: mem_count=0 with out_valid=0 means out_valid stays low. out_ready is ignored.
- Push and load at the same edge with mem_count=32: the load frees a slot, but in_ready was already 0, so no push occurs.
- Reset mid-operation: all state clears immediately and stored words are discarded. RAM contents are not cleared; they are unreachable because the pointers are reset.

## Configuration
- OH_LUTFIFO_FLAGS_EN defined:
  - Adds parameters AFULL (default 28) and AEMPTY (default 2).
  - almost_full = registered (count >= AFULL).
  - almost_empty = registered (count <= AEMPTY).
  - Both flags are updated from next-state count, so they are exact in the same cycle as count.
  - Reset values: almost_full=0, almost_empty=1.
- Not defined: almost_full and almost_empty are tied to 0, and the AFULL/AEMPTY parameters do not exist.

## Structure
- Shared package oh_lutfifo_pkg holds:
  - LF_DEPTH=32
  - LF_AW=5
  - LF_CW=6 (count width)
  - default AFULL/AEMPTY constants
- One natural sub-module: oh_lutfifo_ostage, the output register with load/pop logic and out_valid. Pointer and count logic stays in the top.

## Test plan
- Reset release, then push 0xA5A5A5A5 once -> out_valid rises after second edge, out_data=0xA5A5A5A5, count=1.
- Push 33 words 0..32 with out_ready=0 -> in_ready=0 after 33rd acceptance, count=33. Drain -> values 0..32 in order.
- Continuous push and pop of 100 words (out_ready=1) -> after the initial 2-edge latency, one word out per cycle. Order is preserved across pointer wrap at 31->0.
- With FIFO full, assert out_ready for one cycle while in_valid=1 -> exactly one word out. in_ready rises the next cycle; no word lost or duplicated.
- Assert nreset low mid-stream with count=10 -> all outputs return to reset values. After release, a new push of 0x1 emerges first.
- OH_LUTFIFO_FLAGS_EN defined, AFULL=28, AEMPTY=2 -> almost_full=1 exactly when count>=28. almost_empty=1 exactly when count<=2, including right after reset.
